// File: rtl/dec_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dec_sched_pkg : shared types and constants for decompressor_job_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package dec_sched_pkg;

  localparam int COM_LEN_W = 35;
  localparam int DEC_LEN_W = 32;
  localparam int JOB_LEN_W = COM_LEN_W + DEC_LEN_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    META   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } state_e;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_ZERO    = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;

  // Queue entry is {id, job_len_t}; the id width is a top-level parameter.
  typedef struct packed {
    logic [COM_LEN_W-1:0] com_len;
    logic [DEC_LEN_W-1:0] dec_len;
  } job_len_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_sched_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dec_sched_fifo : shift-register FWFT job queue, head entry is a register
// Rev 1.0
// ---------------------------------------------------------------------------
module dec_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 75
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[0];

  // A pop frees a slot, so a push is accepted while full when popping.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign wr_idx  = pop_ok ? count_q - CW'(1) : count_q;
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      end
      if (push_ok) mem_q[wr_idx[CW-2:0]] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decompressor_job_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decompressor_job_scheduler : queues jobs and sequences them through one
// decompressor wrapper. Optional RUN watchdog: DEC_SCHED_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module decompressor_job_scheduler
  import dec_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int ID_W           = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [ID_W-1:0]      job_id,
  input  logic [COM_LEN_W-1:0] job_com_len,
  input  logic [DEC_LEN_W-1:0] job_dec_len,
  output logic                 cmp_valid,
  input  logic                 cmp_ready,
  output logic [ID_W-1:0]      cmp_id,
  output logic [31:0]          cmp_beats,
  output logic [1:0]           cmp_status,
  output logic                 dec_meta_valid,
  input  logic                 dec_meta_ready,
  output logic [COM_LEN_W-1:0] dec_com_len,
  output logic [DEC_LEN_W-1:0] dec_dec_len,
  output logic                 dec_start,
  input  logic                 dec_done,
  input  logic                 dec_out_valid,
  input  logic                 dec_out_ready,
  output logic                 busy
);

  localparam int REC_W = ID_W + JOB_LEN_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [COM_LEN_W-1:0]   com_q, com_d;
  logic [DEC_LEN_W-1:0]   dec_q, dec_d;
  logic [31:0]            beats_q, beats_d;
  logic [1:0]             status_q, status_d;
  logic                   first_q, first_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]       fifo_dout;
  logic [ID_W-1:0]        head_id;
  job_len_t               head_len;
  logic                   can_start;

  assign {head_id, head_len} = fifo_dout;

`ifdef DEC_SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;
  logic        wait_done_q, wait_done_d;
  // After a timeout the wrapper is still busy; hold off until it finishes.
  assign can_start = !wait_done_q;
`else
  assign can_start = 1'b1;
`endif

  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && can_start;
  assign job_ready = !fifo_full || fifo_pop;
  assign fifo_push = job_valid && job_ready;

  dec_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({job_id, job_com_len, job_dec_len}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    com_d    = com_q;
    dec_d    = dec_q;
    beats_d  = beats_q;
    status_d = status_q;
    first_d  = first_q;
`ifdef DEC_SCHED_TIMEOUT_EN
    tmo_d       = (state_q == RUN) ? tmo_q + 32'd1 : '0;
    wait_done_d = wait_done_q && !dec_done;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          id_d    = head_id;
          com_d   = head_len.com_len;
          dec_d   = head_len.dec_len;
          beats_d = '0;
          if (head_len.dec_len == '0) begin
            status_d = STAT_ZERO;
            state_d  = REPORT;
          end else begin
            state_d  = META;
          end
        end
      end
      META: begin
        if (dec_meta_ready) state_d = START;
      end
      START: begin
        beats_d = '0;
        first_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        first_d = 1'b0;
        if (dec_out_valid && dec_out_ready) beats_d = sat_inc(beats_q);
        // The wrapper registers start, so done is not trusted in the first cycle.
        if (!first_q && dec_done) begin
          status_d = STAT_OK;
          state_d  = REPORT;
        end
`ifdef DEC_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          status_d    = STAT_TIMEOUT;
          state_d     = REPORT;
          wait_done_d = 1'b1;
        end
`endif
      end
      REPORT: begin
        if (cmp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      com_q    <= '0;
      dec_q    <= '0;
      beats_q  <= '0;
      status_q <= STAT_OK;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      com_q    <= com_d;
      dec_q    <= dec_d;
      beats_q  <= beats_d;
      status_q <= status_d;
      first_q  <= first_d;
    end
  end

`ifdef DEC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      wait_done_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      wait_done_q <= wait_done_d;
    end
  end
`endif

  assign dec_meta_valid = (state_q == META);
  assign dec_start      = (state_q == START);
  assign dec_com_len    = com_q;
  assign dec_dec_len    = dec_q;
  assign cmp_valid      = (state_q == REPORT);
  assign cmp_id         = id_q;
  assign cmp_beats      = beats_q;
  assign cmp_status     = status_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_decompressor_job_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decompressor_job_scheduler : scoreboard bench with a behavioural wrapper
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decompressor_job_scheduler;
  import dec_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_id = '0;
  logic [34:0] job_com_len = '0;
  logic [31:0] job_dec_len = '0;
  logic        cmp_valid;
  logic        cmp_ready = 1'b1;
  logic [7:0]  cmp_id;
  logic [31:0] cmp_beats;
  logic [1:0]  cmp_status;
  logic        dec_meta_valid;
  logic        dec_meta_ready = 1'b1;
  logic [34:0] dec_com_len;
  logic [31:0] dec_dec_len;
  logic        dec_start;
  logic        dec_done = 1'b0;
  logic        dec_out_valid = 1'b0;
  logic        dec_out_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  decompressor_job_scheduler #(
    .FIFO_DEPTH     (4),
    .ID_W           (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_com_len(job_com_len), .job_dec_len(job_dec_len),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_beats(cmp_beats), .cmp_status(cmp_status),
    .dec_meta_valid(dec_meta_valid), .dec_meta_ready(dec_meta_ready),
    .dec_com_len(dec_com_len), .dec_dec_len(dec_dec_len),
    .dec_start(dec_start), .dec_done(dec_done),
    .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .busy(busy)
  );

  typedef struct { logic [7:0] id; logic [31:0] beats; logic [1:0] status; } cmp_exp_t;
  typedef struct { logic [34:0] com; logic [31:0] dec; } meta_exp_t;
  typedef struct { int beats; bit early; bit never; int late; } plan_t;

  cmp_exp_t  exp_cmp_q[$];
  meta_exp_t exp_meta_q[$];
  plan_t     plan_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int meta_cnt = 0;
  int nz_cnt = 0;
  int meta_cyc = -10;
  int last_start_cyc = 0;
  int start_cnt = 0;
  bit prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s wait bound expired (t=%0t)", name, $time);
  endfunction

  // Scoreboard monitor: completions, metadata handshakes, start pulses.
  initial begin
    cmp_exp_t  e;
    meta_exp_t m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cmp_q.delete();
        exp_meta_q.delete();
        meta_cnt   = 0;
        nz_cnt     = 0;
        prev_start = 1'b0;
      end else begin
        if (cmp_valid && cmp_ready) begin
          if (exp_cmp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmp_unexpected actual id=%0h required=none", cmp_id);
          end else begin
            e = exp_cmp_q.pop_front();
            chk("cmp_record{id,beats,status}", {cmp_id, cmp_beats, cmp_status},
                {e.id, e.beats, e.status});
            if (e.status != STAT_ZERO) nz_cnt++;
          end
        end
        if (dec_meta_valid && dec_meta_ready) begin
          chk("meta_after_prev_report", meta_cnt, nz_cnt);
          if (exp_meta_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL meta_unexpected actual com=%0h required=none", dec_com_len);
          end else begin
            m = exp_meta_q.pop_front();
            chk("meta_lengths", {dec_com_len, dec_dec_len}, {m.com, m.dec});
          end
          meta_cnt++;
          meta_cyc = cyc;
        end
        if (dec_start) begin
          chk("start_one_after_meta", cyc, meta_cyc + 1);
          chk("start_single_cycle", prev_start, 1'b0);
          last_start_cyc = cyc;
          start_cnt++;
        end
        prev_start = dec_start;
      end
    end
  end

  // Behavioural wrapper: consumes one plan per start pulse.
  task automatic run_plan(input plan_t p);
    int run_cyc = 0;
    bit sent = 1'b0;
    @(negedge clk);
    if (p.early) begin
      dec_done = 1'b1;
      @(negedge clk);
      dec_done = 1'b0;
      run_cyc = 1;
    end
    for (int i = 0; i < p.beats; i++) begin
      dec_out_valid = 1'b1;
      if (!p.never && i == p.beats - 1 && run_cyc > 0) begin
        dec_done = 1'b1;
        sent = 1'b1;
      end
      @(negedge clk);
      run_cyc++;
    end
    dec_out_valid = 1'b0;
    dec_done = 1'b0;
    if (p.never) begin
      if (p.late > 0) begin
        repeat (p.late) @(negedge clk);
        dec_done = 1'b1;
        @(negedge clk);
        dec_done = 1'b0;
      end
      return;
    end
    if (!sent) begin
      dec_done = 1'b1;
      @(negedge clk);
    end
    // Lingering done level and a beat while reporting must both be ignored.
    dec_done = 1'b1;
    dec_out_valid = 1'b1;
    @(negedge clk);
    dec_done = 1'b0;
    dec_out_valid = 1'b0;
  endtask

  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        plan_q.delete();
        dec_done = 1'b0;
        dec_out_valid = 1'b0;
      end else if (dec_start && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        run_plan(p);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(input logic [7:0] id, input logic [34:0] com, input logic [31:0] dec,
                          input int beats, input bit early, input bit never, input int late,
                          input logic [1:0] st, input logic [31:0] exp_beats, output int waited);
    waited = 0;
    while (!job_ready && waited < 300) begin
      tick(1);
      waited++;
    end
    if (!job_ready) begin
      expired("push_job_ready");
      return;
    end
    job_valid = 1'b1;
    job_id = id;
    job_com_len = com;
    job_dec_len = dec;
    exp_cmp_q.push_back('{id, exp_beats, st});
    if (dec != 0) begin
      exp_meta_q.push_back('{com, dec});
      plan_q.push_back('{beats, early, never, late});
    end
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_cmp_q.size() != 0 || busy) && t < 2000) begin
      tick(1);
      t++;
    end
    if (t >= 2000) expired(name);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1'b1);
    chk({tag, "_cmp_valid"}, cmp_valid, 1'b0);
    chk({tag, "_cmp_id"}, cmp_id, 8'd0);
    chk({tag, "_cmp_beats"}, cmp_beats, 32'd0);
    chk({tag, "_cmp_status"}, cmp_status, 2'd0);
    chk({tag, "_meta_valid"}, dec_meta_valid, 1'b0);
    chk({tag, "_com_len"}, dec_com_len, 35'd0);
    chk({tag, "_dec_len"}, dec_dec_len, 32'd0);
    chk({tag, "_start"}, dec_start, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int w;
    int wsum;
    int t;
    int bad;
    int s0;

    rst_n = 1'b0;
    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick(2);

    // Single job, 64 beats.
    s0 = start_cnt;
    push_job(8'd5, 35'd1000, 32'd4096, 64, 0, 0, 0, STAT_OK, 32'd64, w);
    wait_idle("single_idle");
    chk("single_start_count", start_cnt - s0, 1);

    // Four back-to-back jobs.
    wsum = 0;
    push_job(8'd0, 35'd10, 32'd20, 2, 0, 0, 0, STAT_OK, 32'd2, w); wsum += w;
    push_job(8'd1, 35'd11, 32'd21, 3, 0, 0, 0, STAT_OK, 32'd3, w); wsum += w;
    push_job(8'd2, 35'd12, 32'd22, 5, 0, 0, 0, STAT_OK, 32'd5, w); wsum += w;
    push_job(8'd3, 35'd13, 32'd23, 4, 0, 0, 0, STAT_OK, 32'd4, w); wsum += w;
    chk("b2b_ready_stalls", wsum, 0);
    wait_idle("b2b_idle");

    // Zero-length job bypasses the wrapper.
    s0 = start_cnt;
    push_job(8'd9, 35'd77, 32'd0, 0, 0, 0, 0, STAT_ZERO, 32'd0, w);
    wait_idle("zero_idle");
    chk("zero_no_start", start_cnt - s0, 0);

    // Metadata back-pressure, plus a done in the first RUN cycle.
    dec_meta_ready = 1'b0;
    push_job(8'h21, 35'h4_0000_0001, 32'hFFFF_FFFF, 3, 1, 0, 0, STAT_OK, 32'd3, w);
    t = 0;
    while (!dec_meta_valid && t < 50) begin tick(1); t++; end
    if (!dec_meta_valid) expired("meta_stall_valid");
    bad = 0;
    repeat (10) begin
      if (!dec_meta_valid || dec_start || dec_com_len != 35'h4_0000_0001 ||
          dec_dec_len != 32'hFFFF_FFFF) bad++;
      tick(1);
    end
    chk("meta_stall_stable", bad, 0);
    dec_meta_ready = 1'b1;
    wait_idle("meta_stall_idle");

    // Completion back-pressure with the queue filled up.
    cmp_ready = 1'b0;
    push_job(8'h30, 35'd100, 32'd200, 2, 0, 0, 0, STAT_OK, 32'd2, w);
    push_job(8'h31, 35'd101, 32'd201, 6, 0, 0, 0, STAT_OK, 32'd6, w);
    push_job(8'h32, 35'd102, 32'd202, 7, 0, 0, 0, STAT_OK, 32'd7, w);
    push_job(8'h33, 35'd103, 32'd203, 2, 0, 0, 0, STAT_OK, 32'd2, w);
    push_job(8'h34, 35'd104, 32'd204, 3, 0, 0, 0, STAT_OK, 32'd3, w);
    t = 0;
    while (!cmp_valid && t < 100) begin tick(1); t++; end
    if (!cmp_valid) expired("cmp_stall_valid");
    bad = 0;
    repeat (20) begin
      if (!cmp_valid || cmp_id != 8'h30 || cmp_beats != 32'd2 || cmp_status != STAT_OK ||
          dec_start || dec_meta_valid) bad++;
      tick(1);
    end
    chk("cmp_stall_stable", bad, 0);
    chk("fifo_full_ready", job_ready, 1'b0);
    chk("fifo_full_busy", busy, 1'b1);
    cmp_ready = 1'b1;
    push_job(8'h35, 35'd105, 32'd205, 4, 0, 0, 0, STAT_OK, 32'd4, w);
    wait_idle("cmp_stall_idle");

    // Reset in the middle of RUN with another job queued.
    push_job(8'h40, 35'd300, 32'd400, 5, 0, 1, 0, STAT_OK, 32'd0, w);
    push_job(8'h41, 35'd301, 32'd401, 2, 0, 0, 0, STAT_OK, 32'd2, w);
    t = 0;
    while (!dec_start && t < 50) begin tick(1); t++; end
    if (!dec_start) expired("reset_wait_start");
    tick(3);
    rst_n = 1'b0;
    tick(8);
    check_reset("midrst");
    rst_n = 1'b1;
    tick(30);
    check_reset("post_rst");

`ifdef DEC_SCHED_TIMEOUT_EN
    // Watchdog: done never arrives within 100 RUN cycles.
    push_job(8'h50, 35'd500, 32'd800, 3, 0, 1, 150, STAT_TIMEOUT, 32'd3, w);
    t = 0;
    while (!cmp_valid && t < 300) begin tick(1); t++; end
    if (!cmp_valid) expired("tmo_wait_cmp");
    chk("tmo_run_cycles", cyc - last_start_cyc, 101);
    push_job(8'h51, 35'd50, 32'd100, 2, 0, 0, 0, STAT_OK, 32'd2, w);
    bad = 0;
    t = 0;
    while (!dec_done && t < 300) begin
      if (dec_meta_valid) bad++;
      tick(1);
      t++;
    end
    if (!dec_done) expired("tmo_wait_late_done");
    chk("tmo_holds_next_job", bad, 0);
    wait_idle("tmo_idle");
`endif

    wait_idle("final_idle");
    chk("scoreboard_drained", exp_cmp_q.size() + exp_meta_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
